// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter slice.
package mult_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // tdest width for n requesters, never narrower than one bit
    function automatic int unsigned tag_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_pipe.sv
// Pipelined signed multiplier; sideband travels alongside the product with identical delay.
module mult_pipe #(
    parameter int unsigned DATA_W   = mult_arb_pkg::DATA_W,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned TAG_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic                  in_valid,
    input  logic [TAG_W-1:0]      in_tdest,
    input  logic                  in_tlast,
    output logic                  out_valid,
    output logic [2*DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]      out_tdest,
    output logic                  out_tlast
);

    localparam int unsigned PW = 2 * DATA_W;

    logic signed [PW-1:0] prod_c;

    assign prod_c = PW'($signed(a)) * PW'($signed(b));

    if (PIPE_LAT == 0) begin : g_comb
        assign out_valid = in_valid;
        assign out_data  = prod_c;
        assign out_tdest = in_tdest;
        assign out_tlast = in_tlast;
    end else begin : g_regs
        logic [PW-1:0]       data_q  [PIPE_LAT];
        logic [TAG_W-1:0]    tdest_q [PIPE_LAT];
        logic [PIPE_LAT-1:0] valid_q;
        logic [PIPE_LAT-1:0] tlast_q;

        // Multiply lands in the first register so the DSP can absorb it; the rest is a shift chain.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= '0;
                tlast_q <= '0;
                for (int i = 0; i < int'(PIPE_LAT); i++) begin
                    data_q[i]  <= '0;
                    tdest_q[i] <= '0;
                end
            end else if (enable) begin
                valid_q[0] <= in_valid;
                tlast_q[0] <= in_tlast;
                tdest_q[0] <= in_tdest;
                data_q[0]  <= prod_c;
                for (int i = 1; i < int'(PIPE_LAT); i++) begin
                    valid_q[i] <= valid_q[i-1];
                    tlast_q[i] <= tlast_q[i-1];
                    tdest_q[i] <= tdest_q[i-1];
                    data_q[i]  <= data_q[i-1];
                end
            end
        end

        assign out_valid = valid_q[PIPE_LAT-1];
        assign out_data  = data_q[PIPE_LAT-1];
        assign out_tdest = tdest_q[PIPE_LAT-1];
        assign out_tlast = tlast_q[PIPE_LAT-1];
    end

endmodule

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NUM_REQ AXIS requesters.
module mult_rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = mult_arb_pkg::DATA_W,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned LOCK_PKT = 1,
    parameter int unsigned TAG_W    = tag_width(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ*DATA_W-1:0]   s_axis_req_tdata_a,
    input  logic [NUM_REQ*DATA_W-1:0]   s_axis_req_tdata_b,
    input  logic [NUM_REQ-1:0]          s_axis_req_tlast,
    input  logic [NUM_REQ-1:0]          s_axis_req_tvalid,
    output logic [NUM_REQ-1:0]          s_axis_req_tready,
    output logic [2*DATA_W-1:0]         m_axis_result_tdata,
    output logic [TAG_W-1:0]            m_axis_result_tdest,
    output logic                        m_axis_result_tlast,
    output logic                        m_axis_result_tvalid,
    input  logic                        m_axis_result_tready
);

    arb_state_e          state;
    logic [TAG_W-1:0]    rr_ptr;
    logic [TAG_W-1:0]    lock_idx;
    logic [TAG_W-1:0]    cand_c;
    logic [TAG_W-1:0]    grant_c;
    logic                advance_c;
    logic                hs_c;

    logic                s0_valid;
    logic                s0_tlast;
    logic [TAG_W-1:0]    s0_tdest;
    logic [DATA_W-1:0]   s0_a;
    logic [DATA_W-1:0]   s0_b;

    assign advance_c = !m_axis_result_tvalid || m_axis_result_tready;

    // Search downward so the nearest valid index after rr_ptr is the last one written.
    always_comb begin
        logic [TAG_W-1:0] idx;
        idx    = '0;
        cand_c = rr_ptr;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            idx = TAG_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (s_axis_req_tvalid[idx]) begin
                cand_c = idx;
            end
        end
    end

    assign grant_c = (state == LOCKED) ? lock_idx : cand_c;
    assign hs_c    = advance_c && s_axis_req_tvalid[grant_c] && !rst;

    always_comb begin
        s_axis_req_tready = '0;
        if (hs_c) begin
            s_axis_req_tready[grant_c] = 1'b1;
        end
    end

    // Arbitration state, pointer and operand register (stage 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            rr_ptr   <= TAG_W'(NUM_REQ - 1);
            lock_idx <= '0;
            s0_valid <= 1'b0;
            s0_tlast <= 1'b0;
            s0_tdest <= '0;
            s0_a     <= '0;
            s0_b     <= '0;
        end else begin
            if (advance_c) begin
                s0_valid <= hs_c;
            end
            if (hs_c) begin
                s0_a     <= s_axis_req_tdata_a[grant_c*DATA_W +: DATA_W];
                s0_b     <= s_axis_req_tdata_b[grant_c*DATA_W +: DATA_W];
                s0_tlast <= s_axis_req_tlast[grant_c];
                s0_tdest <= grant_c;
                rr_ptr   <= grant_c;
                if (LOCK_PKT != 0) begin
                    case (state)
                        ARB: begin
                            if (!s_axis_req_tlast[grant_c]) begin
                                state    <= LOCKED;
                                lock_idx <= grant_c;
                            end
                        end
                        LOCKED: begin
                            if (s_axis_req_tlast[grant_c]) begin
                                state <= ARB;
                            end
                        end
                        default: state <= ARB;
                    endcase
                end
            end
        end
    end

    mult_pipe #(
        .DATA_W   (DATA_W),
        .PIPE_LAT (PIPE_LAT),
        .TAG_W    (TAG_W)
    ) u_mult_pipe (
        .clk       (clk),
        .rst       (rst),
        .enable    (advance_c),
        .a         (s0_a),
        .b         (s0_b),
        .in_valid  (s0_valid),
        .in_tdest  (s0_tdest),
        .in_tlast  (s0_tlast),
        .out_valid (m_axis_result_tvalid),
        .out_data  (m_axis_result_tdata),
        .out_tdest (m_axis_result_tdest),
        .out_tlast (m_axis_result_tlast)
    );

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Scoreboard bench for mult_rr_arbiter: packet-locking instance plus a per-beat round-robin instance.
`timescale 1ns/1ps
module tb_mult_rr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 64;
    localparam int unsigned TW = 2;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          last;
        int            gap;
    } beat_t;

    typedef struct {
        logic [TW-1:0] tdest;
        logic          tlast;
        logic [PW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic [NR*DW-1:0] s_ta, s_tb;
    logic [NR-1:0]    s_tlast, s_tvalid, s_tready;
    logic [PW-1:0]    m_tdata;
    logic [TW-1:0]    m_tdest;
    logic             m_tlast, m_tvalid, m_tready;

    logic [NR*DW-1:0] rr_ta, rr_tb;
    logic [NR-1:0]    rr_tlast, rr_tvalid, rr_tready;
    logic [PW-1:0]    rr_tdata;
    logic [TW-1:0]    rr_tdest;
    logic             rr_mlast, rr_mvalid;

    beat_t req_q[NR][$];
    exp_t  exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_count = 0;
    int hs_cyc = 0;
    int rr_exp = 0, rr_res = 0, rr_hs = 0, rr_first = -1, rr_last = 0;

    mult_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .PIPE_LAT(2), .LOCK_PKT(1)) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_axis_req_tdata_a   (s_ta),
        .s_axis_req_tdata_b   (s_tb),
        .s_axis_req_tlast     (s_tlast),
        .s_axis_req_tvalid    (s_tvalid),
        .s_axis_req_tready    (s_tready),
        .m_axis_result_tdata  (m_tdata),
        .m_axis_result_tdest  (m_tdest),
        .m_axis_result_tlast  (m_tlast),
        .m_axis_result_tvalid (m_tvalid),
        .m_axis_result_tready (m_tready)
    );

    mult_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .PIPE_LAT(2), .LOCK_PKT(0)) u_rr (
        .clk                  (clk),
        .rst                  (rst),
        .s_axis_req_tdata_a   (rr_ta),
        .s_axis_req_tdata_b   (rr_tb),
        .s_axis_req_tlast     (rr_tlast),
        .s_axis_req_tvalid    (rr_tvalid),
        .s_axis_req_tready    (rr_tready),
        .m_axis_result_tdata  (rr_tdata),
        .m_axis_result_tdest  (rr_tdest),
        .m_axis_result_tlast  (rr_mlast),
        .m_axis_result_tvalid (rr_mvalid),
        .m_axis_result_tready (1'b1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic push_beat(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic last, input int gap);
        beat_t bt;
        bt.a = a; bt.b = b; bt.last = last; bt.gap = gap;
        req_q[r].push_back(bt);
    endtask

    task automatic expect_res(input int dest, input logic last, input logic [PW-1:0] data);
        exp_t e;
        e.tdest = TW'(dest); e.tlast = last; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_hs(input int target, input string name);
        int n;
        n = 0;
        while (hs_count < target && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (hs_count < target) begin
            checks++; failures++;
            $display("FAIL %s timeout handshakes=%0d want=%0d", name, hs_count, target);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, PW'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    // Requester driver: handshakes sampled mid-cycle, next beat presented just after the edge.
    initial begin : driver
        logic [NR-1:0] hs;
        beat_t bt;
        s_tvalid = '0; s_tlast = '0; s_ta = '0; s_tb = '0;
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            if (hs != '0) hs_cyc = cyc;
            @(posedge clk); #1;
            for (int i = 0; i < int'(NR); i++) begin
                if (hs[i] && req_q[i].size() > 0) begin
                    req_q[i].delete(0);
                    hs_count++;
                end
                s_tvalid[i] = 1'b0;
                if (req_q[i].size() > 0) begin
                    bt = req_q[i][0];
                    if (bt.gap > 0) begin
                        bt.gap--;
                        req_q[i][0] = bt;
                    end else begin
                        s_tvalid[i] = 1'b1;
                        s_tlast[i]  = bt.last;
                        s_ta[i*DW +: DW] = bt.a;
                        s_tb[i*DW +: DW] = bt.b;
                    end
                end
            end
        end
    end

    // Result monitor for the locking instance.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_result got tdest=%0d data=0x%0h want no result", m_tdest, m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("result_tdest", PW'(m_tdest), PW'(e.tdest));
                    check("result_tlast", PW'(m_tlast), PW'(e.tlast));
                    check("result_tdata", m_tdata, e.data);
                end
            end
        end
    end

    // Monitor for the per-beat instance: tdest must rotate 0,1,2,3 with product 10*(i+1).
    initial begin : rr_monitor
        forever begin
            @(negedge clk);
            rr_hs += $countones(rr_tready);
            if (rr_mvalid) begin
                check("rr_tdest", PW'(rr_tdest), PW'(rr_exp));
                check("rr_tdata", rr_tdata, PW'(10 * (rr_exp + 1)));
                if (rr_first < 0) rr_first = cyc;
                rr_last = cyc;
                rr_res++;
                rr_exp = (rr_exp + 1) % 4;
            end
        end
    end

    initial begin : main
        int base, n, bubbles, g2;
        logic [PW-1:0] held;
        rst = 1'b1;
        m_tready = 1'b1;
        rr_tvalid = '0;
        rr_tlast = '0;
        for (int i = 0; i < int'(NR); i++) begin
            rr_ta[i*DW +: DW] = DW'(i + 1);
            rr_tb[i*DW +: DW] = DW'(10);
        end
        repeat (3) @(posedge clk);
        #2;
        check("reset_tvalid", PW'(m_tvalid), 0);
        check("reset_tdata", m_tdata, 0);
        check("reset_tready", PW'(s_tready), 0);
        rst = 1'b0;

        // Per-beat arbitration with all requesters valid and tlast low for 12 cycles
        @(posedge clk); #1;
        rr_tvalid = '1;
        repeat (12) @(posedge clk);
        #1;
        rr_tvalid = '0;
        repeat (6) @(negedge clk);
        check("rr_handshakes", PW'(rr_hs), 12);
        check("rr_results", PW'(rr_res), 12);
        check("rr_back_to_back", PW'(rr_last - rr_first), 11);

        // 3 * -5 with latency measurement
        base = hs_count;
        push_beat(0, 32'd3, -32'sd5, 1'b1, 0);
        expect_res(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        wait_hs(base + 1, "t1_hs");
        n = 0;
        while (!m_tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", PW'(cyc - hs_cyc), 3);
        wait_drain("t1_drain");

        // Most negative operands
        push_beat(3, 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
        expect_res(3, 1'b1, 64'h4000_0000_0000_0000);
        wait_drain("t2_drain");

        // All four valid, single-beat packets: rotation 0,1,2,3,0,1,2,3
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < int'(NR); r++) begin
                push_beat(r, DW'(10 * r + k), 32'd7, 1'b1, 0);
                expect_res(r, 1'b1, PW'(70 * r + 7 * k));
            end
        end
        wait_drain("t3_drain");

        // Fill the pipeline then stall downstream for 5 cycles
        base = hs_count;
        for (int j = 0; j < 6; j++) begin
            push_beat(2, DW'(100 + j), -32'sd3, 1'b1, 0);
            expect_res(2, 1'b1, PW'(-3 * (100 + j)));
        end
        wait_hs(base + 4, "t4_fill");
        m_tready = 1'b0;
        held = m_tdata;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_tready", PW'(s_tready), 0);
            check("stall_tvalid", PW'(m_tvalid), 1);
            check("stall_hold", m_tdata, held);
        end
        @(posedge clk); #2;
        m_tready = 1'b1;
        wait_drain("t4_drain");
        check("t4_count", PW'(hs_count - base), 6);

        // Locked 3-beat packet from requester 1 with requester 2 waiting
        push_beat(1, 32'd5, 32'd5, 1'b0, 0);
        push_beat(1, 32'd6, 32'd6, 1'b0, 0);
        push_beat(1, 32'd7, 32'd7, 1'b1, 0);
        push_beat(2, 32'd8, 32'd8, 1'b1, 0);
        push_beat(2, 32'd9, 32'd9, 1'b1, 0);
        expect_res(1, 1'b0, 64'd25);
        expect_res(1, 1'b0, 64'd36);
        expect_res(1, 1'b1, 64'd49);
        expect_res(2, 1'b1, 64'd64);
        expect_res(2, 1'b1, 64'd81);
        wait_drain("t5_drain");

        // Locked requester drops tvalid for 2 cycles mid-packet
        base = hs_count;
        bubbles = 0;
        g2 = 0;
        push_beat(1, 32'd11, 32'd2, 1'b0, 0);
        push_beat(1, 32'd12, 32'd2, 1'b0, 2);
        push_beat(1, 32'd13, 32'd2, 1'b1, 0);
        push_beat(2, 32'd14, 32'd2, 1'b1, 0);
        expect_res(1, 1'b0, 64'd22);
        expect_res(1, 1'b0, 64'd24);
        expect_res(1, 1'b1, 64'd26);
        expect_res(2, 1'b1, 64'd28);
        n = 0;
        while (hs_count < base + 3 && n < 50) begin
            @(negedge clk);
            n++;
            if (hs_count < base + 3) begin
                if (s_tvalid[2] && s_tready == '0) bubbles++;
                if (s_tready[2]) g2++;
            end
        end
        check("lock_bubbles", PW'(bubbles), 2);
        check("lock_no_other_grant", PW'(g2), 0);
        wait_drain("t6_drain");

        // Reset with 3 beats in flight from requester 1
        @(posedge clk); #2;
        m_tready = 1'b0;
        @(negedge clk);
        base = hs_count;
        for (int j = 1; j <= 3; j++) push_beat(1, DW'(j), 32'd1, 1'b1, 0);
        wait_hs(base + 3, "t7_fill");
        check("inflight_tvalid", PW'(m_tvalid), 1);
        rst = 1'b1;
        #1;
        check("async_rst_tvalid", PW'(m_tvalid), 0);
        check("async_rst_tdata", m_tdata, 0);
        check("async_rst_tdest", PW'(m_tdest), 0);
        check("async_rst_tready", PW'(s_tready), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        push_beat(0, 32'd4, 32'd4, 1'b1, 0);
        push_beat(2, 32'd5, 32'd5, 1'b1, 0);
        expect_res(0, 1'b1, 64'd16);
        expect_res(2, 1'b1, 64'd25);
        wait_drain("t7_drain");
        repeat (8) @(negedge clk);

        check("exp_queue_empty", PW'(exp_q.size()), 0);
        check("req_queues_empty", PW'(req_q[0].size() + req_q[1].size() + req_q[2].size() + req_q[3].size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
